// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache arbiter.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   // Index (0 or 1) of the owner encoded in a one-hot grant vector.
   function automatic logic owner_of(input logic [1:0] onehot);
      return onehot[1];
   endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Arbiter-to-controller bus: request fields out, Wait/hit flags/data back.
interface cache_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 8
);
   logic          c_mode;
   logic [AW-1:0] c_address;
   logic [DW-1:0] c_data_in;
   logic          c_wait;
   logic          c_hit1;
   logic          c_hit2;
   logic [DW-1:0] c_data_out;

   modport master (
      output c_mode, c_address, c_data_in,
      input  c_wait, c_hit1, c_hit2, c_data_out
   );

   modport slave (
      input  c_mode, c_address, c_data_in,
      output c_wait, c_hit1, c_hit2, c_data_out
   );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that did not own last wins.
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last_owner,
   output logic [1:0] grant_next
);

   // Priority flips on contention, otherwise the lone requester wins.
   always_comb begin
      grant_next = 2'b00;
      if (req0 && req1) begin
         grant_next = last_owner ? 2'b01 : 2'b10;
      end else if (req0) begin
         grant_next = 2'b01;
      end else if (req1) begin
         grant_next = 2'b10;
      end else begin
         grant_next = 2'b00;
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache_controller port between instruction fetch (port 0) and data (port 1),
// holding the request stable through Wait and aborting via a watchdog.
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 8,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          mode0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          mode1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          hit1_o,
   output logic          hit2_o,
   output logic          err,
   output logic [1:0]    grant,
   cache_port_arbiter_if.master ctrl
);

   localparam int             WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic           WD_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;
   localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

   arb_state_e      state_r, state_next_s;
   logic [1:0]      grant_next_s;
   logic [1:0]      grant_r;
   logic            last_owner_r;
   logic [WD_W-1:0] wd_r, wd_next_s;
   logic            timeout_s;
   logic            c_mode_r;
   logic [AW-1:0]   c_address_r;
   logic [DW-1:0]   c_data_in_r;
   logic            done0_r, done1_r;
   logic [DW-1:0]   rdata_r;
   logic            hit1_r, hit2_r, err_r;

   rr_arb2 u_rr_arb2 (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner_r),
      .grant_next (grant_next_s)
   );

   // Saturating watchdog increment and abort detection.
   always_comb begin
      wd_next_s = wd_r;
      timeout_s = 1'b0;
      if (wd_r == WD_MAX) begin
         wd_next_s = wd_r;
      end else begin
         wd_next_s = wd_r + WD_W'(1);
      end
      if (WD_EN && (wd_next_s == WD_LIMIT)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (req0 || req1) begin
               state_next_s = ISSUE;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: state_next_s = WAIT;
         WAIT: begin
            if (!ctrl.c_wait || timeout_s) begin
               state_next_s = RESP;
            end else begin
               state_next_s = WAIT;
            end
         end
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Request latching, watchdog, response capture and done pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_r      <= 2'b00;
         last_owner_r <= 1'b1;
         wd_r         <= '0;
         c_mode_r     <= MODE_READ;
         c_address_r  <= '0;
         c_data_in_r  <= '0;
         done0_r      <= 1'b0;
         done1_r      <= 1'b0;
         rdata_r      <= '0;
         hit1_r       <= 1'b0;
         hit2_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               if (req0 || req1) begin
                  grant_r      <= grant_next_s;
                  last_owner_r <= owner_of(grant_next_s);
                  c_mode_r     <= grant_next_s[1] ? mode1  : mode0;
                  c_address_r  <= grant_next_s[1] ? addr1  : addr0;
                  c_data_in_r  <= grant_next_s[1] ? wdata1 : wdata0;
               end else begin
                  c_mode_r <= MODE_READ;
               end
            end
            ISSUE: begin
               wd_r <= '0;
            end
            WAIT: begin
               if (!ctrl.c_wait) begin
                  rdata_r <= ctrl.c_data_out;
                  hit1_r  <= ctrl.c_hit1;
                  hit2_r  <= ctrl.c_hit2;
                  err_r   <= 1'b0;
                  done0_r <= grant_r[0];
                  done1_r <= grant_r[1];
               end else begin
                  wd_r <= wd_next_s;
                  if (timeout_s) begin
                     rdata_r <= '0;
                     hit1_r  <= 1'b0;
                     hit2_r  <= 1'b0;
                     err_r   <= 1'b1;
                     done0_r <= grant_r[0];
                     done1_r <= grant_r[1];
                  end
               end
            end
            RESP: begin
               done0_r  <= 1'b0;
               done1_r  <= 1'b0;
               grant_r  <= 2'b00;
               c_mode_r <= MODE_READ;
            end
            default: begin
               done0_r  <= 1'b0;
               done1_r  <= 1'b0;
               grant_r  <= 2'b00;
               c_mode_r <= MODE_READ;
            end
         endcase
      end
   end

   assign done0          = done0_r;
   assign done1          = done1_r;
   assign rdata          = rdata_r;
   assign hit1_o         = hit1_r;
   assign hit2_o         = hit2_r;
   assign err            = err_r;
   assign grant          = grant_r;
   assign ctrl.c_mode    = c_mode_r;
   assign ctrl.c_address = c_address_r;
   assign ctrl.c_data_in = c_data_in_r;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a scripted controller responder and a
// scoreboard of expected grants/responses checked with immediate assertions.
module tb_cache_port_arbiter;
   import cache_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, mode0, req1, mode1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          done0, done1, hit1_o, hit2_o, err;
   logic [DW-1:0] rdata;
   logic [1:0]    grant;

   cache_port_arbiter_if #(.AW(AW), .DW(DW)) cif ();

   cache_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .mode0  (mode0),
      .addr0  (addr0),
      .wdata0 (wdata0),
      .req1   (req1),
      .mode1  (mode1),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .done0  (done0),
      .done1  (done1),
      .rdata  (rdata),
      .hit1_o (hit1_o),
      .hit2_o (hit2_o),
      .err    (err),
      .grant  (grant),
      .ctrl   (cif)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            port;
      logic          mode;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          h1;
      logic          h2;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   int            rsp_wait = 0;
   logic [DW-1:0] rsp_data = 8'h00;
   logic          rsp_h1   = 1'b0;
   logic          rsp_h2   = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Controller model: Wait stays high for rsp_wait WAIT cycles after a grant appears.
   initial begin : responder
      int         n;
      logic [1:0] pg;
      n = 0;
      pg = 2'b00;
      cif.c_wait = 1'b1;
      cif.c_hit1 = 1'b0;
      cif.c_hit2 = 1'b0;
      cif.c_data_out = 8'h00;
      forever begin
         @(negedge clk);
         if (grant != 2'b00 && pg == 2'b00) n = 0;
         else n = n + 1;
         pg = grant;
         cif.c_wait     = (n == 0) ? 1'b1 : (n <= rsp_wait);
         cif.c_data_out = rsp_data;
         cif.c_hit1     = rsp_h1;
         cif.c_hit2     = rsp_h2;
      end
   end

   // Checks bus stability for the current owner and consumes responses on done.
   initial begin : monitor
      exp_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (grant != 2'b00) begin
            if (sb.size() == 0) begin
               check("grant_unexpected", {62'd0, grant}, 64'd0);
            end else begin
               e = sb[0];
               check("grant", {62'd0, grant}, e.port == 1 ? 64'd2 : 64'd1);
               check("c_address", {32'd0, cif.c_address}, {32'd0, e.addr});
               check("c_mode", {63'd0, cif.c_mode}, {63'd0, e.mode});
               check("c_data_in", {56'd0, cif.c_data_in}, {56'd0, e.wdata});
            end
         end
         if (done0 || done1) begin
            check("done_pulse", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
               check("done_unexpected", {62'd0, done1, done0}, 64'd0);
            end else begin
               e = sb.pop_front();
               check("done_port", {62'd0, done1, done0}, e.port == 1 ? 64'd2 : 64'd1);
               check("rdata", {56'd0, rdata}, {56'd0, e.rdata});
               check("hit1_o", {63'd0, hit1_o}, {63'd0, e.h1});
               check("hit2_o", {63'd0, hit2_o}, {63'd0, e.h2});
               check("err", {63'd0, err}, {63'd0, e.err});
            end
         end
         prev_done = done0 | done1;
      end
   end

   task automatic push_exp(input int port, input logic m, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int w, input logic [DW-1:0] d,
                           input logic h1, input logic h2);
      exp_t e;
      e.port  = port;
      e.mode  = m;
      e.addr  = a;
      e.wdata = wd;
      e.rdata = (w >= TO) ? 8'h00 : d;
      e.h1    = (w >= TO) ? 1'b0 : h1;
      e.h2    = (w >= TO) ? 1'b0 : h2;
      e.err   = (w >= TO) ? 1'b1 : 1'b0;
      sb.push_back(e);
   endtask

   task automatic start_req(input int port, input logic m, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int w, input logic [DW-1:0] d,
                            input logic h1, input logic h2);
      @(negedge clk);
      rsp_wait = w;
      rsp_data = d;
      rsp_h1   = h1;
      rsp_h2   = h2;
      push_exp(port, m, a, wd, w, d, h1, h2);
      if (port == 0) begin
         req0 = 1'b1; mode0 = m; addr0 = a; wdata0 = wd;
      end else begin
         req1 = 1'b1; mode1 = m; addr1 = a; wdata1 = wd;
      end
   endtask

   // Latency counts edges from the sampling edge to the edge that consumes done.
   task automatic wait_done(input string tag, input int exp_lat, input int chg_at,
                            input logic [AW-1:0] chg_addr);
      int cnt;
      bit seen;
      cnt = 0;
      seen = 1'b0;
      @(posedge clk);
      while (!seen && cnt < 100) begin
         @(negedge clk);
         if (done0 || done1) begin
            seen = 1'b1;
         end else begin
            if (cnt == chg_at) begin
               addr0 = chg_addr;
               addr1 = chg_addr;
            end
            @(posedge clk);
            cnt++;
         end
      end
      if (!seen) check({tag, "_no_done"}, 64'd0, 64'd1);
      else check({tag, "_latency"}, cnt + 1, exp_lat);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin : global_bound
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation bound exceeded");
   end

   initial begin : stim
      int ndone;
      reset = 1'b1;
      req0 = 1'b0; mode0 = MODE_READ; addr0 = 32'h0; wdata0 = 8'h00;
      req1 = 1'b0; mode1 = MODE_READ; addr1 = 32'h0; wdata1 = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_grant", {62'd0, grant}, 64'd0);
      check("rst_done", {62'd0, done1, done0}, 64'd0);
      check("rst_rdata", {56'd0, rdata}, 64'd0);
      check("rst_flags", {61'd0, hit1_o, hit2_o, err}, 64'd0);
      check("rst_c_mode", {63'd0, cif.c_mode}, 64'd0);
      check("rst_c_address", {32'd0, cif.c_address}, 64'd0);
      check("rst_c_data_in", {56'd0, cif.c_data_in}, 64'd0);
      reset = 1'b0;

      // Single read hit on port 0.
      start_req(0, MODE_READ, 32'h0000_0000, 8'h00, 0, 8'hA5, 1'b1, 1'b0);
      wait_done("read_hit", 3, -1, 32'h0);

      // Port 1 write with four Wait cycles.
      start_req(1, MODE_WRITE, 32'h0000_0080, 8'h3C, 4, 8'h5A, 1'b0, 1'b1);
      wait_done("write_wait4", 7, -1, 32'h0);

      // Both ports held for four accesses: expect 0,1,0,1.
      @(negedge clk);
      rsp_wait = 0; rsp_data = 8'h11; rsp_h1 = 1'b1; rsp_h2 = 1'b1;
      push_exp(0, MODE_READ, 32'h0000_0100, 8'h21, 0, 8'h11, 1'b1, 1'b1);
      push_exp(1, MODE_WRITE, 32'h0000_0200, 8'h42, 0, 8'h11, 1'b1, 1'b1);
      push_exp(0, MODE_READ, 32'h0000_0100, 8'h21, 0, 8'h11, 1'b1, 1'b1);
      push_exp(1, MODE_WRITE, 32'h0000_0200, 8'h42, 0, 8'h11, 1'b1, 1'b1);
      req0 = 1'b1; mode0 = MODE_READ;  addr0 = 32'h0000_0100; wdata0 = 8'h21;
      req1 = 1'b1; mode1 = MODE_WRITE; addr1 = 32'h0000_0200; wdata1 = 8'h42;
      ndone = 0;
      for (int i = 0; i < 200 && ndone < 4; i++) begin
         @(negedge clk);
         if (done0 || done1) ndone++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("rr_done_count", ndone, 64'd4);
      check("rr_queue_drained", sb.size(), 64'd0);

      // Watchdog abort, then a normal access clears err.
      start_req(0, MODE_READ, 32'h0000_0040, 8'h00, 1000, 8'hEE, 1'b1, 1'b1);
      wait_done("timeout", 10, -1, 32'h0);
      start_req(1, MODE_READ, 32'h0000_0044, 8'h00, 0, 8'h77, 1'b0, 1'b1);
      wait_done("after_timeout", 3, -1, 32'h0);

      // Address change during WAIT must not reach the controller.
      start_req(0, MODE_READ, 32'h0000_0048, 8'h00, 3, 8'h99, 1'b1, 1'b0);
      wait_done("addr_hold", 6, 2, 32'hFFFF_FFF0);

      // Reset asserted mid-WAIT drops the access.
      start_req(0, MODE_WRITE, 32'h0000_1234, 8'h5C, 1000, 8'h00, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      req0 = 1'b0;
      check("mid_rst_grant", {62'd0, grant}, 64'd0);
      check("mid_rst_c_address", {32'd0, cif.c_address}, 64'd0);
      check("mid_rst_c_data_in", {56'd0, cif.c_data_in}, 64'd0);
      check("mid_rst_c_mode", {63'd0, cif.c_mode}, 64'd0);
      check("mid_rst_rdata", {56'd0, rdata}, 64'd0);
      check("mid_rst_done", {62'd0, done1, done0}, 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // First tie after reset goes to port 0.
      @(negedge clk);
      rsp_wait = 0; rsp_data = 8'h33; rsp_h1 = 1'b1; rsp_h2 = 1'b0;
      push_exp(0, MODE_READ, 32'h0000_0010, 8'h01, 0, 8'h33, 1'b1, 1'b0);
      req0 = 1'b1; mode0 = MODE_READ; addr0 = 32'h0000_0010; wdata0 = 8'h01;
      req1 = 1'b1; mode1 = MODE_READ; addr1 = 32'h0000_0020; wdata1 = 8'h02;
      wait_done("tie_after_reset", 3, -1, 32'h0);
      repeat (3) @(negedge clk);
      check("final_queue_drained", sb.size(), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
